// File: rtl/knn_pkg.sv
// Shared encodings and width helpers for the KNN host sequencer.
// Pure declarations: no timing, no flow control.
// Nothing here drives or applies backpressure.
package knn_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DIMENSIONS_DEF = 32;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_REF     = 4'd2,
        S_DATA    = 4'd3,
        S_DRAIN   = 4'd4,
        S_DONE    = 4'd5,
        S_READ    = 4'd6,
        S_WAIT_RD = 4'd7,
        S_OUT     = 4'd8
    } seq_state_t;

    // Bits needed for a counter holding 0..n-1 (never narrower than one bit).
    function automatic int val_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/knn_seq_result_buf.sv
// Delays a core read pulse by RD_LAT cycles, captures the core result, presents it on res_*.
// Latency: capture RD_LAT cycles after rd_en, res_valid the cycle after.
// Backpressure: holds res_* stable until res_ready; the caller never issues a second read meanwhile.
module knn_seq_result_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 2
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  is_last,
    input  logic [31:0]           name_in,
    input  logic [DATA_WIDTH-1:0] value_in,
    input  logic                  res_ready,
    output logic                  cap,
    output logic                  res_valid,
    output logic [31:0]           res_name,
    output logic [DATA_WIDTH-1:0] res_value,
    output logic                  res_last
);

    logic [RD_LAT-1:0] rd_dly;

    // Core outputs are valid during the cycle this delayed pulse is high.
    assign cap = rd_dly[RD_LAT-1];

    always_ff @(posedge mclk) begin
        if (reset) begin
            rd_dly    <= '0;
            res_valid <= 1'b0;
            res_name  <= '0;
            res_value <= '0;
            res_last  <= 1'b0;
        end else begin
            rd_dly <= RD_LAT'({rd_dly, rd_en});
            if (cap) begin
                res_valid <= 1'b1;
                res_name  <= name_in;
                res_value <= value_in;
                res_last  <= is_last;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
                res_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/knn_host_sequencer.sv
// Host-side job sequencer for the KNN core: start, reference + N data vectors, drain, K result reads.
// Latency: knn_wr_en/knn_data one cycle after each accepted beat; KNN_SEQ_PERF_EN adds perf_cycles.
// Backpressure: in_ready only in REF/DATA, cmd_ready only in IDLE; results held until res_ready.
module knn_host_sequencer
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIMENSIONS = DIMENSIONS_DEF,
    parameter int NUM_CH     = 1,
    parameter int K          = 1,
    parameter int CNT_W      = 16,
    parameter int DRAIN_CYC  = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                         mclk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [CNT_W-1:0]             cmd_num_points,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         knn_wr_en,
    output logic                         knn_start,
    output logic                         knn_done,
    output logic                         knn_rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] knn_data,
    input  logic [31:0]                  knn_name_in,
    input  logic [DATA_WIDTH-1:0]        knn_value_in,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [31:0]                  res_name,
    output logic [DATA_WIDTH-1:0]        res_value,
    output logic                         res_last,
`ifdef KNN_SEQ_PERF_EN
    output logic [31:0]                  perf_cycles,
`endif
    output logic                         busy
);

    localparam int WCNT_W = val_width(DIMENSIONS);
    localparam int DCNT_W = val_width(DRAIN_CYC + 1);
    localparam int RCNT_W = val_width(K);

    seq_state_t        state, state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [CNT_W-1:0]  pcnt;
    logic [CNT_W-1:0]  n_pts;
    logic [DCNT_W-1:0] dcnt;
    logic [RCNT_W-1:0] rcnt;
    logic              beat;
    logic              word_last;
    logic              point_last;
    logic              drain_end;
    logic              res_is_last;
    logic              cap;
    logic              res_hs;

    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = (state == S_REF) || (state == S_DATA);
    assign knn_start = (state == S_START);
    assign knn_done  = (state == S_DONE);
    assign knn_rd_en = (state == S_READ);
    assign busy      = (state != S_IDLE);

    assign beat        = in_valid && in_ready;
    assign word_last   = (wcnt == WCNT_W'(DIMENSIONS - 1));
    assign point_last  = (pcnt == n_pts - CNT_W'(1));
    // DRAIN also covers the cycle of the last knn_wr_en, hence DRAIN_CYC+1 cycles.
    assign drain_end   = (dcnt == DCNT_W'(DRAIN_CYC));
    assign res_is_last = (rcnt == RCNT_W'(K - 1));
    assign res_hs      = res_valid && res_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (cmd_valid && cmd_num_points != '0) state_nxt = S_START;
            S_START:   state_nxt = S_REF;
            S_REF:     if (beat && word_last) state_nxt = S_DATA;
            S_DATA:    if (beat && word_last && point_last) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_end) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_READ;
            S_READ:    state_nxt = S_WAIT_RD;
            S_WAIT_RD: if (cap) state_nxt = S_OUT;
            S_OUT:     if (res_hs) state_nxt = res_is_last ? S_IDLE : S_READ;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            pcnt      <= '0;
            n_pts     <= '0;
            dcnt      <= '0;
            rcnt      <= '0;
            knn_wr_en <= 1'b0;
            knn_data  <= '0;
        end else begin
            state     <= state_nxt;
            knn_wr_en <= beat;
            if (beat) begin
                knn_data <= in_data;
                wcnt     <= word_last ? '0 : wcnt + WCNT_W'(1);
                if (state == S_DATA && word_last)
                    pcnt <= point_last ? '0 : pcnt + CNT_W'(1);
            end
            if (state == S_IDLE && cmd_valid)
                n_pts <= cmd_num_points;
            dcnt <= (state == S_DRAIN) ? dcnt + DCNT_W'(1) : '0;
            if (state == S_IDLE)
                rcnt <= '0;
            else if (res_hs)
                rcnt <= rcnt + RCNT_W'(1);
        end
    end

`ifdef KNN_SEQ_PERF_EN
    // Counts START through the final result handshake, then holds until the next accept.
    always_ff @(posedge mclk) begin
        if (reset)
            perf_cycles <= '0;
        else if (state == S_IDLE && cmd_valid)
            perf_cycles <= '0;
        else if (state != S_IDLE && perf_cycles != '1)
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

    knn_seq_result_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LAT    (RD_LAT)
    ) u_res_buf (
        .mclk     (mclk),
        .reset    (reset),
        .rd_en    (knn_rd_en),
        .is_last  (res_is_last),
        .name_in  (knn_name_in),
        .value_in (knn_value_in),
        .res_ready(res_ready),
        .cap      (cap),
        .res_valid(res_valid),
        .res_name (res_name),
        .res_value(res_value),
        .res_last (res_last)
    );

endmodule

// File: tb/tb_knn_host_sequencer.sv
// Randomised job-level bench for knn_host_sequencer with a behavioural accelerator-core model.
// Expected timing and results are derived from job parameters and the data the bench sends.
module tb_knn_host_sequencer;

    localparam int DW  = 32;
    localparam int DIM = 4;
    localparam int NCH = 2;
    localparam int KK  = 3;
    localparam int CW  = 8;
    localparam int DRN = 8;
    localparam int RL  = 2;
    localparam int W   = NCH * DW;

    logic          mclk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_num_points = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          knn_wr_en, knn_start, knn_done, knn_rd_en;
    logic [W-1:0]  knn_data;
    logic [31:0]   knn_name_in = '0;
    logic [DW-1:0] knn_value_in = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [31:0]   res_name;
    logic [DW-1:0] res_value;
    logic          res_last;
    logic          busy;
`ifdef KNN_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    knn_host_sequencer #(
        .DATA_WIDTH(DW), .DIMENSIONS(DIM), .NUM_CH(NCH), .K(KK),
        .CNT_W(CW), .DRAIN_CYC(DRN), .RD_LAT(RL)
    ) dut (
        .mclk(mclk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_points(cmd_num_points),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .knn_wr_en(knn_wr_en), .knn_start(knn_start), .knn_done(knn_done),
        .knn_rd_en(knn_rd_en), .knn_data(knn_data),
        .knn_name_in(knn_name_in), .knn_value_in(knn_value_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_name(res_name),
        .res_value(res_value), .res_last(res_last),
`ifdef KNN_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .busy(busy)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int failures = 0;
    int job_no = 0;
    int excl_viol = 0;

    int cyc = 0;
    int start_q[$], wr_cyc_q[$], acc_q[$], done_q[$], rd_q[$], vrise_q[$], hs_q[$];
    logic [W-1:0]  wr_dat_q[$];
    logic [31:0]   hs_name_q[$];
    logic [DW-1:0] hs_val_q[$];
    logic          hs_last_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor plus accelerator-core model: the core sums every written word since knn_start,
    // and answers each read RL cycles later with name={job,rank}, value=sum+rank.
    initial begin : monitor
        int core_job, core_rank, core_due;
        logic [DW-1:0] core_sum;
        logic prev_valid;
        core_job = 0; core_rank = 0; core_due = 0; core_sum = '0; prev_valid = 1'b0;
        forever begin
            @(negedge mclk);
            cyc++;
            if (reset) core_due = 0;
            if (int'(knn_wr_en) + int'(knn_start) + int'(knn_done) + int'(knn_rd_en) > 1)
                excl_viol++;
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (knn_start) begin
                start_q.push_back(cyc);
                core_job++; core_rank = 0; core_sum = '0;
            end
            if (knn_wr_en) begin
                wr_cyc_q.push_back(cyc);
                wr_dat_q.push_back(knn_data);
                for (int c = 0; c < NCH; c++) core_sum += knn_data[c*DW +: DW];
            end
            if (knn_done) done_q.push_back(cyc);
            if (knn_rd_en) begin
                rd_q.push_back(cyc);
                knn_name_in  = $urandom;
                knn_value_in = $urandom;
                core_due = RL;
            end else if (core_due > 0) begin
                core_due--;
                if (core_due == 0) begin
                    knn_name_in  = 32'(core_job * 256 + core_rank);
                    knn_value_in = core_sum + DW'(core_rank);
                    core_rank++;
                end
            end
            if (res_valid && !prev_valid) vrise_q.push_back(cyc);
            prev_valid = res_valid;
            if (res_valid && res_ready) begin
                hs_q.push_back(cyc);
                hs_name_q.push_back(res_name);
                hs_val_q.push_back(res_value);
                hs_last_q.push_back(res_last);
            end
        end
    end

    task automatic clear_logs();
        start_q.delete(); wr_cyc_q.delete(); acc_q.delete(); done_q.delete();
        rd_q.delete(); vrise_q.delete(); hs_q.delete(); wr_dat_q.delete();
        hs_name_q.delete(); hs_val_q.delete(); hs_last_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, {cmd_ready, in_ready, knn_wr_en, knn_start, knn_done,
                             knn_rd_en, res_valid, res_last, busy}, 9'b100000000);
        check({tag, "_data"}, knn_data, '0);
        check({tag, "_res"}, {res_name, res_value}, '0);
    endtask

    // mode 0: in_valid always high; 1: toggling; 2: random with cmd_valid held high meanwhile.
    task automatic run_job(input int n, input int mode, input int hold, input int abort_at);
        logic [W-1:0] beats[$];
        logic [W-1:0] b;
        logic [DW-1:0] exp_sum;
        int total, idx, budget, err_d, err_c, s;
        total = (n + 1) * DIM;
        exp_sum = '0;
        for (int i = 0; i < total; i++) begin
            b = {$urandom, $urandom};
            beats.push_back(b);
            for (int c = 0; c < NCH; c++) exp_sum += b[c*DW +: DW];
        end
        clear_logs();
        @(posedge mclk); #1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_num_points = CW'(n);
        @(posedge mclk); #1;
        cmd_valid = 1'b0;
        job_no++;
        idx = 0; budget = 0;
        while (idx < total && budget < 400) begin
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((budget % 2) == 0)
                                                          : 1'($urandom_range(0, 1));
            in_data = beats[idx];
            if (mode == 2) begin cmd_valid = 1'b1; cmd_num_points = CW'(3); end
            @(negedge mclk);
            if (in_valid && in_ready) idx++;
            if (abort_at > 0 && idx == abort_at) break;
            @(posedge mclk); #1;
            budget++;
        end
        if (abort_at > 0) begin
            @(posedge mclk); #1;
            in_valid = 1'b0;
            reset = 1'b1;
            @(posedge mclk); #1;
            reset = 1'b0;
            @(negedge mclk);
            check_idle_outputs("abort");
            return;
        end
        in_valid = 1'b0;
        cmd_valid = 1'b0;
        check("beats_accepted", idx, total);

        for (int r = 0; r < KK; r++) begin
            budget = 0;
            while (!res_valid && budget < 200) begin @(negedge mclk); budget++; end
            check($sformatf("res_valid%0d", r), res_valid, 1'b1);
            repeat (hold) @(negedge mclk);
            @(posedge mclk); #1;
            res_ready = 1'b1;
            @(posedge mclk); #1;
            res_ready = 1'b0;
        end
        repeat (2) @(negedge mclk);
        check("idle_after", {busy, cmd_ready}, 2'b01);

        check("start_cnt", start_q.size(), 1);
        s = (start_q.size() > 0) ? start_q[0] : 0;
        check("wr_cnt", wr_cyc_q.size(), total);
        err_d = 0; err_c = 0;
        for (int i = 0; i < total && i < wr_dat_q.size(); i++) begin
            if (wr_dat_q[i] !== beats[i]) err_d++;
            if (i >= acc_q.size() || wr_cyc_q[i] != acc_q[i] + 1) err_c++;
        end
        check("wr_data_err", err_d, 0);
        check("wr_gap_err", err_c, 0);
        if (mode == 0 && wr_cyc_q.size() == total) begin
            check("wr_first_cyc", wr_cyc_q[0], s + 2);
            check("wr_last_cyc", wr_cyc_q[total-1], s + 1 + total);
        end
        check("done_cnt", done_q.size(), 1);
        if (done_q.size() > 0 && wr_cyc_q.size() > 0)
            check("done_cyc", done_q[0], wr_cyc_q[wr_cyc_q.size()-1] + DRN + 1);
        check("rd_cnt", rd_q.size(), KK);
        check("hs_cnt", hs_q.size(), KK);
        for (int r = 0; r < KK; r++) begin
            if (r < rd_q.size() && r < hs_q.size() && r < vrise_q.size() && done_q.size() > 0) begin
                check($sformatf("rd_cyc%0d", r), rd_q[r], (r == 0) ? done_q[0] + 1 : hs_q[r-1] + 1);
                check($sformatf("vrise%0d", r), vrise_q[r], rd_q[r] + RL + 1);
                check($sformatf("res_name%0d", r), hs_name_q[r], 32'(job_no * 256 + r));
                check($sformatf("res_value%0d", r), hs_val_q[r], exp_sum + DW'(r));
                check($sformatf("res_last%0d", r), hs_last_q[r], r == KK - 1);
            end
        end
`ifdef KNN_SEQ_PERF_EN
        if (hs_q.size() == KK) check("perf_cycles", perf_cycles, hs_q[KK-1] - s + 1);
`endif
        check("excl_viol", excl_viol, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(posedge mclk);
        #1 reset = 1'b0;
        @(negedge mclk);
        check_idle_outputs("reset");

        run_job(2, 0, 0, 0);
        run_job(2, 1, 0, 0);
        run_job(1, 2, 5, 0);

        clear_logs();
        @(posedge mclk); #1;
        cmd_valid = 1'b1;
        cmd_num_points = '0;
        @(posedge mclk); #1;
        cmd_valid = 1'b0;
        @(negedge mclk);
        check("n0_ready", {cmd_ready, busy}, 2'b10);
        repeat (20) @(negedge mclk);
        check("n0_events", start_q.size() + wr_cyc_q.size() + done_q.size() + rd_q.size(), 0);

        run_job(2, 0, 0, 6);
        run_job(2, 0, 1, 0);

        for (int j = 0; j < 3; j++)
            run_job($urandom_range(1, 3), 2, $urandom_range(0, 3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
